// File: rtl/ray_pkg.sv
// Shared ray payload definitions for the camera-ray interface.
package ray_pkg;

    localparam int unsigned POSITION_WIDTH_DEFAULT = 16;
    localparam int unsigned ADDRESS_WIDTH_DEFAULT  = 32;

    typedef struct packed {
        logic [2:0][POSITION_WIDTH_DEFAULT-1:0] v;
        logic [ADDRESS_WIDTH_DEFAULT-1:0]       address;
    } ray_t;

    // Flattened width of one ray: three vector components plus the pixel address.
    function automatic int unsigned ray_bits(input int unsigned pw, input int unsigned aw);
        return 3 * pw + aw;
    endfunction

endpackage

// File: rtl/ray_fifo.sv
// Synchronous FIFO holding flattened rays between the generator and the output stage.
module ray_fifo
    import ray_pkg::*;
#(
    parameter int unsigned WIDTH = ray_bits(POSITION_WIDTH_DEFAULT, ADDRESS_WIDTH_DEFAULT),
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next_c;

    assign head         = mem[rd_ptr];
    assign count_next_c = count + CNT_W'(push) - CNT_W'(pop);

    // Storage is not reset; stale entries are never read because count gates the head.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; flags track the next count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
            empty <= (count_next_c == '0);
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Buffers rays from the generator and hands each one to a ray unit chosen round-robin.
module ray_dispatcher
    import ray_pkg::*;
#(
    parameter int unsigned POSITION_WIDTH = POSITION_WIDTH_DEFAULT,
    parameter int unsigned ADDRESS_WIDTH  = ADDRESS_WIDTH_DEFAULT,
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned DEPTH          = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic signed [2:0][POSITION_WIDTH-1:0] rayV,
    input  logic [ADDRESS_WIDTH-1:0]             rayAddress,
    input  logic                                 rayStart,
    output logic                                 rayReady,
    output logic                                 rayBusy,
    output logic signed [2:0][POSITION_WIDTH-1:0] unitV,
    output logic [ADDRESS_WIDTH-1:0]             unitAddress,
    output logic [NUM_UNITS-1:0]                 unitStart,
    input  logic [NUM_UNITS-1:0]                 unitReady,
    input  logic [NUM_UNITS-1:0]                 unitBusy
);

    localparam int unsigned RAY_W = ray_bits(POSITION_WIDTH, ADDRESS_WIDTH);
    localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [RAY_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             push_c;
    logic             pop_c;
    logic             accept_c;
    logic             stage_free_c;
    logic             pick_found_c;
    logic [IDX_W-1:0] pick_c;
    logic [IDX_W-1:0] last_grant;
    int unsigned      scan_idx_c;

    ray_fifo #(
        .WIDTH (RAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   ({rayV, rayAddress}),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The stage is valid exactly when one unitStart bit is set.
    assign push_c       = rayStart & ~fifo_full;
    assign accept_c     = |(unitStart & unitReady);
    assign stage_free_c = ~(|unitStart) | accept_c;
    assign pop_c        = stage_free_c & ~fifo_empty & pick_found_c;

    assign rayReady = ~fifo_full;
    assign rayBusy  = (fifo_count != '0) | (|unitStart) | (|unitBusy);

    // First ready unit scanning upward from the one after the last grant, with wrap.
    always_comb begin
        pick_c       = last_grant;
        pick_found_c = 1'b0;
        scan_idx_c   = 0;
        for (int unsigned k = 1; k <= NUM_UNITS; k++) begin
            scan_idx_c = (32'(last_grant) + k) % NUM_UNITS;
            if (!pick_found_c && unitReady[IDX_W'(scan_idx_c)]) begin
                pick_c       = IDX_W'(scan_idx_c);
                pick_found_c = 1'b1;
            end
        end
    end

    // Output stage: a loaded target is held until that unit accepts, even if its ready drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            unitStart   <= '0;
            unitV       <= '0;
            unitAddress <= '0;
            last_grant  <= IDX_W'(NUM_UNITS - 1);
        end else if (pop_c) begin
            unitStart                <= NUM_UNITS'(1) << pick_c;
            {unitV, unitAddress}     <= fifo_head;
            last_grant               <= pick_c;
        end else if (accept_c) begin
            unitStart <= '0;
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed and randomized checks of ray_dispatcher against a queue-based scoreboard.
module tb_ray_dispatcher;
    import ray_pkg::*;

    logic                   clk;
    logic                   reset;
    logic signed [2:0][15:0] ray_v;
    logic [31:0]            ray_address;
    logic                   ray_start;
    logic                   ray_ready;
    logic                   ray_busy;
    logic signed [2:0][15:0] unit_v;
    logic [31:0]            unit_address;
    logic [3:0]             unit_start;
    logic [3:0]             unit_ready;
    logic [3:0]             unit_busy;

    ray_dispatcher dut (
        .clock       (clk),
        .reset       (reset),
        .rayV        (ray_v),
        .rayAddress  (ray_address),
        .rayStart    (ray_start),
        .rayReady    (ray_ready),
        .rayBusy     (ray_busy),
        .unitV       (unit_v),
        .unitAddress (unit_address),
        .unitStart   (unit_start),
        .unitReady   (unit_ready),
        .unitBusy    (unit_busy)
    );

    always #5 clk = ~clk;

    int         checks;
    int         failures;
    ray_t       q[$];
    int         last_grant;
    bit         prev_pending;
    logic [3:0] prev_start;
    logic [3:0] prev_ready;
    logic [79:0] prev_data;
    bit         in_acc;
    int         n_out;
    logic [3:0] acc_mask;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] rdy, input int last);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (last + k) % 4;
            if (rdy[2'(idx)]) return idx;
        end
        return -1;
    endfunction

    // Scoreboard step, evaluated mid-cycle when all inputs are stable.
    task automatic monitor();
        ray_t       r;
        int         tgt;
        logic [3:0] exp_start;
        bit         out_acc;
        if (reset) begin
            q.delete();
            last_grant   = 3;
            prev_pending = 0;
            prev_ready   = unit_ready;
            in_acc       = 0;
            return;
        end
        check("ray_busy", ray_busy, (q.size() != 0) || (unit_busy != 0));
        if (q.size() < 8) check("ray_ready_open", ray_ready, 1);
        if (q.size() == 9) check("ray_ready_full", ray_ready, 0);
        check("start_onehot", $countones(unit_start) <= 1, 1);
        if (prev_pending) begin
            check("hold_start", unit_start, prev_start);
            check("hold_data", {unit_v, unit_address}, prev_data);
        end else if (unit_start != 0) begin
            tgt       = rr_pick(prev_ready, last_grant);
            exp_start = (tgt < 0) ? 4'd0 : 4'(1 << tgt);
            check("rr_target", unit_start, exp_start);
            if (tgt >= 0) last_grant = tgt;
        end
        out_acc = (unit_start & unit_ready) != 0;
        if (out_acc) begin
            n_out++;
            acc_mask |= unit_start;
            check("out_has_ray", q.size() != 0, 1);
            if (q.size() != 0) begin
                r = q.pop_front();
                check("out_data", {unit_v, unit_address}, r);
            end
        end
        in_acc = ray_start && ray_ready;
        if (in_acc) begin
            r.v       = ray_v;
            r.address = ray_address;
            q.push_back(r);
        end
        prev_pending = (unit_start != 0) && !out_acc;
        prev_start   = unit_start;
        prev_data    = {unit_v, unit_address};
        prev_ready   = unit_ready;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0][15:0] v, input logic [31:0] a);
        bit done;
        done        = 0;
        ray_start   = 1;
        ray_v       = v;
        ray_address = a;
        for (int n = 0; n < 100 && !done; n++) begin
            cycle();
            done = in_acc;
        end
        check("send_accepted", done, 1);
        ray_start = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (q.size() == 0 && unit_start == 0) break;
            cycle();
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int          base;
        logic [79:0] held;
        clk = 0; reset = 1; ray_v = '0; ray_address = '0; ray_start = 0;
        unit_ready = '0; unit_busy = '0;
        checks = 0; failures = 0; last_grant = 3; prev_pending = 0;
        prev_start = '0; prev_ready = '0; prev_data = '0; in_acc = 0; n_out = 0; acc_mask = '0;

        cycle(); cycle();
        reset = 0;
        check("rst_start", unit_start, 0);
        check("rst_ready", ray_ready, 1);
        check("rst_busy", ray_busy, 0);
        check("rst_v", unit_v, 0);
        check("rst_addr", unit_address, 0);

        // Four back-to-back rays, all units ready: targets 0..3 starting two cycles after push.
        unit_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            ray_start   = 1;
            ray_address = 32'(i);
            ray_v[0] = 16'(i * 3); ray_v[1] = 16'(i + 100); ray_v[2] = 16'(-i);
            cycle();
            if (i == 0) check("t1_latency", unit_start, 0);
            else begin
                check("t1_start", unit_start, 4'(1 << (i - 1)));
                check("t1_addr", unit_address, i - 1);
            end
        end
        ray_start = 0;
        cycle();
        check("t1_start", unit_start, 4'b1000);
        check("t1_addr", unit_address, 3);
        cycle();
        check("t1_idle", unit_start, 0);

        // Fill the FIFO with no unit ready; the ninth ray must be held by the sender.
        unit_ready = 4'h0;
        base = n_out;
        for (int i = 0; i < 8; i++) send({16'(i), 16'(-i), 16'(7 * i)}, 32'h1000 + 32'(i));
        check("t2_full_ready", ray_ready, 0);
        check("t2_busy", ray_busy, 1);
        ray_start = 1; ray_address = 32'h1008; ray_v = {16'h8000, 16'h0000, 16'h7fff};
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t2_held", in_acc, 0);
        end
        unit_ready = 4'hF;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (in_acc) break;
        end
        check("t2_ninth_taken", in_acc, 1);
        ray_start = 0;
        drain();
        check("t2_delivered", n_out - base, 9);

        // Only unit 2 ever ready, pulsed every third cycle: one ray per pulse.
        unit_ready = 4'h0;
        for (int i = 0; i < 3; i++) send({16'(i), 16'(i), 16'(i)}, 32'h2000 + 32'(i));
        cycle();
        base = n_out; acc_mask = '0;
        for (int c = 0; c < 12; c++) begin
            unit_ready = (c % 3 == 2) ? 4'b0100 : 4'b0000;
            cycle();
        end
        check("t3_count", n_out - base, 3);
        check("t3_target", acc_mask, 4'b0100);

        // Offer to unit 1 held steady while its ready is low.
        unit_ready = 4'h0;
        send({16'h1234, 16'hfedc, 16'h0042}, 32'hcafe0001);
        cycle();
        unit_ready = 4'b0010;
        cycle();
        unit_ready = 4'h0;
        check("t4_loaded", unit_start, 4'b0010);
        held = {unit_v, unit_address};
        check("t4_data", held, {16'h1234, 16'hfedc, 16'h0042, 32'hcafe0001});
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t4_hold_start", unit_start, 4'b0010);
            check("t4_hold_data", {unit_v, unit_address}, held);
        end
        unit_ready = 4'b0010;
        cycle();
        check("t4_released", unit_start, 0);

        // Reset mid-operation discards buffered rays.
        unit_ready = 4'h0;
        for (int i = 0; i < 5; i++) send({16'(i), 16'(i), 16'(i)}, 32'h3000 + 32'(i));
        check("t5_busy_before", ray_busy, 1);
        reset = 1;
        cycle();
        reset = 0;
        check("t5_start", unit_start, 0);
        check("t5_ready", ray_ready, 1);
        check("t5_busy", ray_busy, 0);
        check("t5_addr", unit_address, 0);
        unit_busy = 4'b1000;
        #1;
        check("t5_busy_units", ray_busy, 1);
        unit_busy = 4'h0;
        base = n_out;
        unit_ready = 4'hF;
        for (int i = 0; i < 10; i++) cycle();
        check("t5_no_stale", n_out - base, 0);

        // Random traffic with a mid-run reset.
        ray_start = 0;
        for (int c = 0; c < 10000; c++) begin
            reset = (c == 5000);
            if (!ray_start || in_acc) begin
                ray_start   = ($urandom_range(0, 3) != 0);
                ray_address = $urandom;
                if ($urandom_range(0, 15) == 0) ray_v = {16'h8000, 16'h0000, 16'h7fff};
                else begin
                    ray_v[0] = 16'($urandom); ray_v[1] = 16'($urandom); ray_v[2] = 16'($urandom);
                end
            end
            if ((c / 500) % 2 == 0) unit_ready = 4'($urandom & $urandom & $urandom);
            else unit_ready = 4'($urandom);
            unit_busy = 4'($urandom);
            cycle();
        end
        reset = 0; ray_start = 0; unit_ready = 4'hF; unit_busy = 4'h0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
